// File: rtl/ripple_count_capture.sv
// Ripple counter capture: synchronises raw JK ripple Q bits,
// filters ripple transients and publishes settled counts.
module ripple_count_capture #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ripple_q,
  input  logic [WIDTH-1:0] match_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             count_valid,
  output logic             wrap,
  output logic             err,
  output logic             match
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int SW = 4;
  localparam logic [SW-1:0] THR  = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             match_q, match_d;
  logic [1:0]       state_q, state_d;
  logic             first_q, first_d;
  logic             pub;
  logic             err_set;

  // Filter, FSM and publish decision for the next edge
  always_comb begin
    s1_d    = ripple_q;
    s2_d    = s1_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    count_d = count_q;
    state_d = state_q;
    first_d = first_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_set = 1'b0;
    pub     = 1'b0;
    if (s2_q != cand_q) begin
      cand_d  = s2_q;
      stab_d  = SW'(1);
      state_d = first_q ? IDLE : SETTLE;
    end else begin
      if (stab_q < SMAX)
        stab_d = stab_q + SW'(1);
      if (stab_q == THR) begin
        pub     = (state_q == IDLE) || (cand_q != count_q);
        state_d = LOCKED;
      end
    end
    if (pub) begin
      count_d = cand_q;
      valid_d = 1'b1;
      first_d = 1'b0;
      if (!first_q) begin
        wrap_d  = cand_q < count_q;
        err_set = cand_q != (count_q + WIDTH'(1));
      end
    end
    err_d   = err_set | (err_q & ~err_clr);
    match_d = (count_q == match_val);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      match_q <= 1'b0;
      state_q <= IDLE;
      first_q <= 1'b1;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      count_q <= count_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      match_q <= match_d;
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign wrap        = wrap_q;
  assign err         = err_q;
  assign match       = match_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture: run-length model
// of the synchronised sample stream predicts every publish.
module tb_ripple_count_capture;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] ripple_q = '0;
  logic [W-1:0] match_val = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] count;
  logic         count_valid;
  logic         wrap;
  logic         err;
  logic         match;

  ripple_count_capture #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk(clk),
    .reset(reset),
    .ripple_q(ripple_q),
    .match_val(match_val),
    .err_clr(err_clr),
    .count(count),
    .count_valid(count_valid),
    .wrap(wrap),
    .err(err),
    .match(match)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int v;
    bit wr;
    bit es;
  } exp_t;
  exp_t q[$];

  int run_v = -1;
  int run_len = 0;
  int last = 0;
  bit first = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One synchronised sample: a run of S equal samples is settled
  function automatic void gen_sample(input int v);
    exp_t e;
    if (v == run_v) run_len++;
    else begin
      run_v = v;
      run_len = 1;
    end
    if (run_len == S && (first || v != last)) begin
      e.v = v;
      e.wr = !first && (v < last);
      e.es = !first && (v != ((last + 1) % (1 << W)));
      q.push_back(e);
      last = v;
      first = 1'b0;
    end
  endfunction

  task automatic model_reset();
    q.delete();
    run_v = -1;
    run_len = 0;
    last = 0;
    first = 1'b1;
  endtask

  // Called at posedge+2; synchroniser zeros lead the stream
  task automatic release_rst();
    reset = 1'b1;
    model_reset();
    gen_sample(0);
    gen_sample(0);
  endtask

  task automatic cyc(input int v, input int n, input int clr_mode);
    for (int i = 0; i < n; i++) begin
      ripple_q = v[W-1:0];
      if (clr_mode == 0) err_clr = 1'b0;
      else if (clr_mode == 1) err_clr = 1'b1;
      else err_clr = ($urandom_range(0, 7) == 0);
      gen_sample(v);
      @(posedge clk);
      #2;
    end
    err_clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_valid"}, int'(count_valid), 0);
    chk({tag, "_wrap"}, int'(wrap), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_match"}, int'(match), 0);
  endtask

  bit   rst_prev = 1'b0;
  int   m_count = 0;
  bit   m_err = 1'b0;
  bit   pend_match = 1'b0;
  bit   clr_prev = 1'b0;
  bit   es_now;
  exp_t e_now;

  always @(negedge clk) begin
    if (!reset || !rst_prev) begin
      m_count = 0;
      m_err = 1'b0;
      pend_match = (match_val == 0);
      clr_prev = err_clr;
    end else begin
      es_now = 1'b0;
      if (count_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_publish actual=%0d required=none", count);
        end else begin
          e_now = q.pop_front();
          chk("pub_count", int'(count), e_now.v);
          chk("pub_wrap", int'(wrap), int'(e_now.wr));
          m_count = e_now.v;
          es_now = e_now.es;
        end
      end else begin
        chk("wrap_idle", int'(wrap), 0);
      end
      m_err = es_now | (m_err & !clr_prev);
      chk("err", int'(err), int'(m_err));
      chk("count_hold", int'(count), m_count);
      chk("match", int'(match), int'(pend_match));
      pend_match = (m_count == int'(match_val));
      clr_prev = err_clr;
    end
    rst_prev = reset;
  end

  int pv;
  int nv;

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    release_rst();
    cyc(0, 8, 0);
    cyc(1, 8, 0);
    cyc(2, 8, 0);
    cyc(3, 8, 0);
    cyc(7, 8, 0);
    cyc(6, 1, 0);
    cyc(4, 1, 0);
    cyc(0, 1, 0);
    cyc(8, 8, 0);
    for (int v = 9; v < 16; v++) cyc(v, 4, 0);
    cyc(0, 8, 0);
    cyc(3, 8, 0);
    cyc(9, 8, 0);
    cyc(9, 1, 1);
    cyc(9, 4, 0);
    cyc(2, 3, 0);
    cyc(2, 1, 1);
    cyc(2, 4, 0);
    match_val = 4'd5;
    cyc(4, 6, 0);
    cyc(5, 8, 0);
    cyc(7, 2, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    chk_zero("async_rst");
    ripple_q = '0;
    match_val = '0;
    repeat (3) @(posedge clk);
    #2;
    release_rst();
    cyc(0, 4, 0);
    cyc(1, 6, 0);
    pv = 1;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 3) == 0) nv = (pv + 1) % 16;
      else nv = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0) match_val = 4'($urandom_range(0, 15));
      cyc(nv, $urandom_range(1, 5), 2);
      pv = nv;
    end
    cyc(pv, 6, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
